rename_map_mp: RTL and testbench

RENAME_MAP_MP -- requirements
Module: rename_map_mp

---
 rtl/rename_map_mp.sv | 112 +++++++++++
 tb/tb_rename_map_mp.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_map_mp.sv
// rtl/rename_map_mp.sv - multi-ported register rename map with speculative and committed tables
// Renames WIDTH slots per cycle with intra-group bypass; commits update the stable map, rewind restores from it.
module rename_map_mp #(
   parameter int N_ARCH = 32,
   parameter int ARCH_W = 5,
   parameter int PHYS_W = 6,
   parameter int WIDTH  = 4,
   parameter int SRCS   = 3
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            en,
   input  logic                            rewind,
   input  logic [WIDTH-1:0]                resValid,
   input  logic [WIDTH*ARCH_W-1:0]         resSel,
   input  logic [WIDTH*PHYS_W-1:0]         resPhys,
   input  logic [WIDTH-1:0]                comValid,
   input  logic [WIDTH*ARCH_W-1:0]         comSel,
   input  logic [WIDTH*PHYS_W-1:0]         comPhys,
   input  logic [WIDTH*SRCS*ARCH_W-1:0]    srcSel,
   output logic [WIDTH*SRCS*PHYS_W-1:0]    srcPhys,
   output logic [WIDTH*PHYS_W-1:0]         oldPhys,
   output logic                            outValid,
   input  logic [ARCH_W-1:0]               stableSel,
   output logic [PHYS_W-1:0]               stablePhys
);

   logic [PHYS_W-1:0] newest     [N_ARCH];
   logic [PHYS_W-1:0] stable     [N_ARCH];
   logic [PHYS_W-1:0] newestNext [N_ARCH];
   logic [PHYS_W-1:0] stableNext [N_ARCH];

   logic [WIDTH*SRCS*PHYS_W-1:0] srcNext;
   logic [WIDTH*PHYS_W-1:0]      oldNext;
   logic                         doRename;

   // Widened compare so the range test stays meaningful when N_ARCH == 2**ARCH_W.
   function automatic logic inRange(input logic [ARCH_W-1:0] sel);
      logic [31:0] wide;
      wide = 32'(sel);
      return wide < 32'(N_ARCH);
   endfunction

   // Youngest older slot in the group reserving the key wins; otherwise the speculative table.
   function automatic logic [PHYS_W-1:0] bypassRead(input int slot, input logic [ARCH_W-1:0] key);
      logic [PHYS_W-1:0] val;
      val = '0;
      if (inRange(key)) begin
         val = newest[key];
         for (int t = 0; t < WIDTH; t++) begin
            if (t < slot && resValid[t] && resSel[t*ARCH_W +: ARCH_W] == key)
               val = resPhys[t*PHYS_W +: PHYS_W];
         end
      end
      return val;
   endfunction

   assign doRename = en && !rewind;

   always_comb begin
      stableNext = stable;
      for (int k = 0; k < WIDTH; k++) begin
         if (comValid[k] && inRange(comSel[k*ARCH_W +: ARCH_W]))
            stableNext[comSel[k*ARCH_W +: ARCH_W]] = comPhys[k*PHYS_W +: PHYS_W];
      end
   end

   always_comb begin
      newestNext = newest;
      if (rewind) begin
         newestNext = stableNext;
      end else if (en) begin
         for (int k = 0; k < WIDTH; k++) begin
            if (resValid[k] && inRange(resSel[k*ARCH_W +: ARCH_W]))
               newestNext[resSel[k*ARCH_W +: ARCH_W]] = resPhys[k*PHYS_W +: PHYS_W];
         end
      end
   end

   always_comb begin
      srcNext = '0;
      oldNext = '0;
      for (int s = 0; s < WIDTH; s++) begin
         for (int j = 0; j < SRCS; j++)
            srcNext[(s*SRCS+j)*PHYS_W +: PHYS_W] = bypassRead(s, srcSel[(s*SRCS+j)*ARCH_W +: ARCH_W]);
         oldNext[s*PHYS_W +: PHYS_W] = bypassRead(s, resSel[s*ARCH_W +: ARCH_W]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < N_ARCH; i++) begin
            newest[i] <= PHYS_W'(i);
            stable[i] <= PHYS_W'(i);
         end
         srcPhys  <= '0;
         oldPhys  <= '0;
         outValid <= 1'b0;
      end else begin
         newest   <= newestNext;
         stable   <= stableNext;
         outValid <= doRename;
         if (doRename) begin
            srcPhys <= srcNext;
            oldPhys <= oldNext;
         end
      end
   end

   assign stablePhys = inRange(stableSel) ? stable[stableSel] : '0;

endmodule

// File: tb/tb_rename_map_mp.sv
// tb/tb_rename_map_mp.sv - self-checking bench for rename_map_mp
// Sequential-rename reference model compared every cycle, plus hand-computed directed checks.
module tb_rename_map_mp;

   localparam int W  = 4;
   localparam int SR = 3;
   localparam int AW = 5;
   localparam int PW = 6;
   localparam int NA = 24;

   logic              clk = 1'b0;
   logic              reset;
   logic              en;
   logic              rewind;
   logic [W-1:0]      resValid;
   logic [W*AW-1:0]   resSel;
   logic [W*PW-1:0]   resPhys;
   logic [W-1:0]      comValid;
   logic [W*AW-1:0]   comSel;
   logic [W*PW-1:0]   comPhys;
   logic [W*SR*AW-1:0] srcSel;
   logic [W*SR*PW-1:0] srcPhys;
   logic [W*PW-1:0]   oldPhys;
   logic              outValid;
   logic [AW-1:0]     stableSel;
   logic [PW-1:0]     stablePhys;

   int checks = 0;
   int errors = 0;

   rename_map_mp #(.N_ARCH(NA), .ARCH_W(AW), .PHYS_W(PW), .WIDTH(W), .SRCS(SR)) dut (
      .clk(clk), .reset(reset), .en(en), .rewind(rewind),
      .resValid(resValid), .resSel(resSel), .resPhys(resPhys),
      .comValid(comValid), .comSel(comSel), .comPhys(comPhys),
      .srcSel(srcSel), .srcPhys(srcPhys), .oldPhys(oldPhys), .outValid(outValid),
      .stableSel(stableSel), .stablePhys(stablePhys)
   );

   always #5 clk = ~clk;

   // Reference model: rename the slots one after another against a working copy of the map.
   logic [PW-1:0]      mNew [NA];
   logic [PW-1:0]      mStab[NA];
   logic [PW-1:0]      tS   [NA];
   logic [PW-1:0]      tN   [NA];
   logic [W*SR*PW-1:0] expSrc;
   logic [W*PW-1:0]    expOld;
   logic               expValid;
   bit                 armed = 0;
   int                 key;

   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NA; i++) begin
            mNew[i]  = PW'(i);
            mStab[i] = PW'(i);
         end
         expSrc   = '0;
         expOld   = '0;
         expValid = 1'b0;
         armed    = 1;
      end else begin
         tS = mStab;
         for (int k = 0; k < W; k++) begin
            key = int'(comSel[k*AW +: AW]);
            if (comValid[k] && key < NA) tS[key] = comPhys[k*PW +: PW];
         end
         if (rewind) begin
            mNew     = tS;
            expValid = 1'b0;
         end else if (en) begin
            tN = mNew;
            for (int s = 0; s < W; s++) begin
               for (int j = 0; j < SR; j++) begin
                  key = int'(srcSel[(s*SR+j)*AW +: AW]);
                  expSrc[(s*SR+j)*PW +: PW] = (key < NA) ? tN[key] : '0;
               end
               key = int'(resSel[s*AW +: AW]);
               expOld[s*PW +: PW] = (key < NA) ? tN[key] : '0;
               if (resValid[s] && key < NA) tN[key] = resPhys[s*PW +: PW];
            end
            mNew     = tN;
            expValid = 1'b1;
         end else begin
            expValid = 1'b0;
         end
         mStab = tS;
      end
   end

   int          sk;
   logic [PW-1:0] expStable;

   always @(negedge clk) begin
      if (armed) begin
         sk = int'(stableSel);
         expStable = (sk < NA) ? mStab[sk] : '0;
         checks++;
         if (srcPhys !== expSrc) begin
            errors++;
            $display("FAIL model_srcPhys t=%0t actual=%h required=%h", $time, srcPhys, expSrc);
         end
         checks++;
         if (oldPhys !== expOld) begin
            errors++;
            $display("FAIL model_oldPhys t=%0t actual=%h required=%h", $time, oldPhys, expOld);
         end
         checks++;
         if (outValid !== expValid) begin
            errors++;
            $display("FAIL model_outValid t=%0t actual=%b required=%b", $time, outValid, expValid);
         end
         checks++;
         if (stablePhys !== expStable) begin
            errors++;
            $display("FAIL model_stablePhys t=%0t sel=%0d actual=%0d required=%0d", $time, sk, stablePhys, expStable);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic int srcOf(input int s, input int j);
      return int'(srcPhys[(s*SR+j)*PW +: PW]);
   endfunction

   function automatic int oldOf(input int s);
      return int'(oldPhys[s*PW +: PW]);
   endfunction

   task automatic clr();
      en = 0; rewind = 0;
      resValid = '0; resSel = '0; resPhys = '0;
      comValid = '0; comSel = '0; comPhys = '0;
      srcSel = '0;
   endtask

   task automatic setRes(input int k, input int sel, input int phys);
      resValid[k] = 1'b1;
      resSel[k*AW +: AW]  = AW'(sel);
      resPhys[k*PW +: PW] = PW'(phys);
   endtask

   task automatic setCom(input int k, input int sel, input int phys);
      comValid[k] = 1'b1;
      comSel[k*AW +: AW]  = AW'(sel);
      comPhys[k*PW +: PW] = PW'(phys);
   endtask

   task automatic setSrc(input int s, input int j, input int sel);
      srcSel[(s*SR+j)*AW +: AW] = AW'(sel);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chkStable(input string nm, input int sel, input int exp);
      stableSel = AW'(sel);
      #1;
      chk(nm, int'(stablePhys), exp);
   endtask

   initial begin
      clr();
      reset = 0;
      stableSel = '0;
      tick();
      tick();
      chk("rst_outValid", int'(outValid), 0);
      chk("rst_srcPhys_nonzero", (srcPhys == '0) ? 0 : 1, 0);
      chk("rst_oldPhys_nonzero", (oldPhys == '0) ? 0 : 1, 0);
      reset = 1;
      chkStable("rst_stable9", 9, 9);

      clr(); en = 1; setSrc(0, 0, 5);
      tick();
      chk("basic_src00", srcOf(0, 0), 5);
      chk("basic_outValid", int'(outValid), 1);

      clr(); en = 1; setRes(0, 3, 40); setSrc(2, 1, 3); setSrc(0, 0, 3); setSrc(0, 2, 3);
      tick();
      chk("bypass_src21", srcOf(2, 1), 40);
      chk("bypass_src00", srcOf(0, 0), 3);
      chk("bypass_src02", srcOf(0, 2), 3);
      chk("bypass_old0", oldOf(0), 3);
      clr(); en = 1; setSrc(0, 0, 3);
      tick();
      chk("bypass_next_src00", srcOf(0, 0), 40);

      clr(); en = 1; setRes(1, 7, 50); setRes(3, 7, 51);
      tick();
      chk("dup_old3", oldOf(3), 50);
      chk("dup_old1", oldOf(1), 7);
      clr(); en = 1; setSrc(1, 2, 7);
      tick();
      chk("dup_next_src12", srcOf(1, 2), 51);

      clr(); en = 1; rewind = 1; setRes(0, 4, 33); setCom(0, 4, 20); setCom(2, 4, 21);
      tick();
      chk("rewind_outValid", int'(outValid), 0);
      chk("rewind_hold_src12", srcOf(1, 2), 51);
      chkStable("rewind_stable4", 4, 21);
      clr(); en = 1; setSrc(0, 0, 4); setSrc(0, 1, 7);
      tick();
      chk("rewind_next_src00", srcOf(0, 0), 21);
      chk("rewind_next_src01", srcOf(0, 1), 7);

      clr(); setCom(0, 9, 44);
      tick();
      chk("idle_outValid", int'(outValid), 0);
      chk("idle_hold_src00", srcOf(0, 0), 21);
      chkStable("idle_stable9", 9, 44);
      clr(); en = 1; setSrc(3, 2, 9);
      tick();
      chk("idle_newest9", srcOf(3, 2), 9);

      clr(); en = 1; setRes(0, 30, 12); setSrc(1, 0, 30); setCom(1, 28, 5);
      tick();
      chk("oor_src10", srcOf(1, 0), 0);
      chk("oor_old0", oldOf(0), 0);
      chkStable("oor_stable28", 28, 0);

      for (int i = 0; i < 40; i++) begin
         clr();
         en     = ($urandom_range(0, 3) != 0);
         rewind = ($urandom_range(0, 7) == 0);
         for (int k = 0; k < W; k++) begin
            if ($urandom_range(0, 1) == 1) setRes(k, $urandom_range(0, 9), $urandom_range(0, 63));
            if ($urandom_range(0, 2) == 0) setCom(k, $urandom_range(0, 9), $urandom_range(0, 63));
            for (int j = 0; j < SR; j++)
               setSrc(k, j, ($urandom_range(0, 15) == 0) ? 26 : $urandom_range(0, 9));
         end
         stableSel = AW'($urandom_range(0, 25));
         tick();
      end

      clr(); reset = 0; en = 1; setRes(0, 3, 60); setCom(0, 3, 61);
      tick();
      chk("midrst_outValid", int'(outValid), 0);
      chk("midrst_srcPhys_nonzero", (srcPhys == '0) ? 0 : 1, 0);
      chk("midrst_oldPhys_nonzero", (oldPhys == '0) ? 0 : 1, 0);
      reset = 1;
      chkStable("midrst_stable3", 3, 3);
      clr(); en = 1; setSrc(0, 0, 3); setSrc(0, 1, 7); setSrc(0, 2, 4);
      tick();
      chk("midrst_src00", srcOf(0, 0), 3);
      chk("midrst_src01", srcOf(0, 1), 7);
      chk("midrst_src02", srcOf(0, 2), 4);
      chk("midrst_outValid_after", int'(outValid), 1);
      clr();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
